// File: rtl/lpc_autocorr.sv
// lpc_autocorr -- autocorrelation lags R[0..P] of one N-sample speech frame.
//
// R[k] = sum_{n=k}^{N-1} x[n]*x[n-k], k = 0..P. The frame is read through two
// synchronous read ports (data one cycle after address). The products are
// accumulated, and each finished lag is written to the coefficient register file.
// done pulses once after R[P] is written and starts the Levinson-Durbin stage.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 single-cycle request to process the buffered frame
//   x_raddr_a/x_rdata_a   frame port A (index n)
//   x_raddr_b/x_rdata_b   frame port B (index n-k)
//   r_waddr/r_wdata/r_wen lag write port (k, R[k], strobe)
//   busy                  high in RUN, FLUSH and WRITE
//   done                  one-cycle pulse after R[P] is written
module lpc_autocorr #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int N      = 160,
  parameter int P      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        x_raddr_a,
  output logic [7:0]        x_raddr_b,
  input  logic [DATA_W-1:0] x_rdata_a,
  input  logic [DATA_W-1:0] x_rdata_b,
  output logic [3:0]        r_waddr,
  output logic [ACC_W-1:0]  r_wdata,
  output logic              r_wen,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [7:0] N_LAST = 8'(N - 1);
  localparam logic [3:0] K_LAST = 4'(P);

  logic [2:0]              state;
  logic [3:0]              k;
  logic [7:0]              n;
  logic [7:0]              n_next;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_sum;
  logic                    mac_valid;
  logic signed [2*DATA_W-1:0] prod;

  // Accumulated value including the product of the read issued last cycle.
  always_comb begin
    prod    = $signed(x_rdata_a) * $signed(x_rdata_b);
    acc_sum = acc;
    if (mac_valid)
      acc_sum = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  assign n_next = n + 8'd1;
  assign busy   = (state == RUN) || (state == FLUSH) || (state == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      acc       <= '0;
      mac_valid <= 1'b0;
      x_raddr_a <= '0;
      x_raddr_b <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            k         <= '0;
            n         <= '0;
            acc       <= '0;
            mac_valid <= 1'b0;
            x_raddr_a <= '0;
            x_raddr_b <= '0;
          end
        end
        RUN: begin
          // Addresses are registered so they are stable for the whole RUN
          // cycle; mac_valid tracks that a read is in flight.
          acc       <= acc_sum;
          mac_valid <= 1'b1;
          if (n == N_LAST) begin
            state <= FLUSH;
          end else begin
            n         <= n_next;
            x_raddr_a <= n_next;
            x_raddr_b <= n_next - {4'd0, k};
          end
        end
        FLUSH: begin
          // Final product lands here; the write port is loaded directly so
          // r_wen/r_wdata are valid throughout the WRITE cycle.
          acc       <= acc_sum;
          mac_valid <= 1'b0;
          r_wdata   <= acc_sum;
          r_waddr   <= k;
          r_wen     <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          r_wen     <= 1'b0;
          acc       <= '0;
          mac_valid <= 1'b0;
          if (k == K_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            k         <= k + 4'd1;
            n         <= {4'd0, k} + 8'd1;
            x_raddr_a <= {4'd0, k} + 8'd1;
            x_raddr_b <= '0;
            state     <= RUN;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          r_wen <= 1'b0;
        end
      endcase
    end
  end

endmodule
